// File: rtl/imem_loader.sv
// Byte-serial instruction-memory loader: 16-bit word count, then 4 bytes per word (MSB first).
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] ADDR_BASE = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_write_en,
    output logic [31:0] o_data,
    output logic [31:0] o_addr_wr,
    output logic        o_stall,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        BYTES  = 3'd3,
        WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK  = 3'd5,
`endif
        FINISH = 3'd6
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHECK;
`else
    localparam state_t END_STATE = FINISH;
`endif

    localparam logic [16:0] MAX_WORDS = 17'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] k_q, k_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic        write_en_q, write_en_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;

    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Running XOR over every count and data byte accepted in the current load
    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && i_start) begin
            csum_d = 8'h00;
        end else if (i_rx_valid && (state_q == CNT_HI || state_q == CNT_LO || state_q == BYTES)) begin
            csum_d = csum_fold(csum_q, i_rx_data);
        end else begin
            csum_d = csum_q;
        end
    end
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        error_d    = error_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d    = CNT_HI;
                    error_d    = 1'b0;
                    cnt_d      = 16'h0000;
                    k_d        = 16'h0000;
                    byte_cnt_d = 2'd0;
                    addr_d     = ADDR_BASE;
                end else begin
                    state_d = IDLE;
                end
            end
            CNT_HI: begin
                if (i_rx_valid) begin
                    cnt_d   = {i_rx_data, cnt_q[7:0]};
                    state_d = CNT_LO;
                end else begin
                    state_d = CNT_HI;
                end
            end
            CNT_LO: begin
                if (i_rx_valid) begin
                    cnt_d = {cnt_q[15:8], i_rx_data};
                    if (cnt_d == 16'h0000) begin
                        state_d = END_STATE;
                    end else if ({1'b0, cnt_d} > MAX_WORDS) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = BYTES;
                    end
                end else begin
                    state_d = CNT_LO;
                end
            end
            BYTES: begin
                if (i_rx_valid) begin
                    word_d     = {word_q[23:0], i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end else begin
                        state_d = BYTES;
                    end
                end else begin
                    state_d = BYTES;
                end
            end
            WRITE: begin
                // addr_q already holds ADDR_BASE + 4*k for this write; advance for the next one
                k_d    = k_q + 16'd1;
                addr_d = addr_q + 32'd4;
                if (k_d == cnt_q) begin
                    state_d = END_STATE;
                end else begin
                    state_d = BYTES;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (i_rx_valid) begin
                    if (i_rx_data == csum_q) begin
                        state_d = FINISH;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = CHECK;
                end
            end
`endif
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        write_en_d = (state_d == WRITE);
        done_d     = (state_d == FINISH);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= 16'h0000;
            k_q        <= 16'h0000;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'h0000_0000;
            addr_q     <= ADDR_BASE;
            write_en_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            write_en_q <= write_en_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign o_write_en = write_en_q;
    assign o_data     = word_q;
    assign o_addr_wr  = addr_q;
    assign o_busy     = (state_q != IDLE);
    assign o_stall    = o_busy;
    assign o_done     = done_q;
    assign o_error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a transaction-level load model.
module tb_imem_loader;

    localparam int          MEM_WORDS = 256;
    localparam logic [31:0] ADDR_BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        write_en;
    logic [31:0] data;
    logic [31:0] addr;
    logic        stall;
    logic        busy;
    logic        done;
    logic        error;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] wr_log[$];
    int          done_cnt = 0;
    logic [31:0] words_q[$];

    imem_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_BASE(ADDR_BASE)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_write_en(write_en), .o_data(data), .o_addr_wr(addr),
        .o_stall(stall), .o_busy(busy), .o_done(done), .o_error(error)
    );

    always #5 clk = ~clk;

    // Record every write strobe and done pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (write_en === 1'b1) wr_log.push_back({addr, data});
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals();
        check_eq("rst_we",    32'(write_en), 32'd0);
        check_eq("rst_data",  data,          32'd0);
        check_eq("rst_addr",  addr,          ADDR_BASE);
        check_eq("rst_stall", 32'(stall),    32'd0);
        check_eq("rst_busy",  32'(busy),     32'd0);
        check_eq("rst_done",  32'(done),     32'd0);
        check_eq("rst_err",   32'(error),    32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
        for (int i = 0; i < gap; i++) begin
            start = noise && ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // One complete load; words come from words_q, expectations from the byte-stream rules
    task automatic run_load(input logic [15:0] cnt, input logic [7:0] csum_xor,
                            input bit noise, input int max_gap);
        int          wbase, dbase, nw, next_min;
        bit          over, exp_done;
        logic [7:0]  cs, b;
        logic [31:0] w;
        logic [63:0] e;
        wbase    = wr_log.size();
        dbase    = done_cnt;
        over     = (int'(cnt) > MEM_WORDS);
        exp_done = 1'b0;
        next_min = 0;
        pulse_start();
        check_eq("err_clr", 32'(error), 32'd0);
        check_eq("busy",    32'(busy),  32'd1);
        check_eq("stall",   32'(stall), 32'd1);
        send_byte(cnt[15:8], $urandom_range(0, max_gap), noise);
        send_byte(cnt[7:0],  $urandom_range(0, max_gap), noise);
        cs = cnt[15:8] ^ cnt[7:0];
        if (over) begin
            check_eq("err_set",  32'(error), 32'd1);
            check_eq("err_idle", 32'(busy),  32'd0);
        end else begin
            for (int k = 0; k < int'(cnt); k++) begin
                w = words_q[k];
                for (int j = 0; j < 4; j++) begin
                    b  = w[31 - 8*j -: 8];
                    cs = cs ^ b;
                    send_byte(b, next_min + int'($urandom_range(0, max_gap)), noise);
                    next_min = 0;
                end
                check_eq("wr_lat", 32'(write_en), 32'd1);
                if ($urandom_range(0, 1) == 1) begin
                    send_byte(8'($urandom), 0, 1'b0);
                end else begin
                    next_min = 1;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(cs ^ csum_xor, next_min + int'($urandom_range(0, max_gap)), noise);
            exp_done = (csum_xor == 8'h00);
            check_eq("csum_done", 32'(done),  32'(exp_done));
            check_eq("csum_err",  32'(error), 32'(!exp_done));
`else
            exp_done = 1'b1;
            if (cnt == 16'h0000) check_eq("zero_done", 32'(done), 32'd1);
`endif
        end
        for (int i = 0; i < 8 && busy; i++) begin
            @(posedge clk); #1;
        end
        check_eq("idle", 32'(busy), 32'd0);
        nw = over ? 0 : int'(cnt);
        check_eq("n_wr", 32'(wr_log.size() - wbase), 32'(nw));
        for (int k = 0; k < nw && (wbase + k) < wr_log.size(); k++) begin
            e = wr_log[wbase + k];
            check_eq("wr_addr", e[63:32], ADDR_BASE + 32'(4 * k));
            check_eq("wr_data", e[31:0],  words_q[k]);
        end
        check_eq("n_done",    32'(done_cnt - dbase), 32'(exp_done));
        check_eq("err_final", 32'(error),            32'(!exp_done));
    endtask

    task automatic fill_random(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wbase, n;
        logic [7:0] cx;
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;

        send_byte(8'hA5, 0, 1'b0);
        check_eq("idle_drop", 32'(busy), 32'd0);

        words_q.delete();
        words_q.push_back(32'h2008_0005);
        words_q.push_back(32'h8C09_0004);
        run_load(16'd2, 8'h00, 1'b0, 0);

        words_q.delete();
        run_load(16'h0000, 8'h00, 1'b0, 1);

        run_load(16'h0101, 8'h00, 1'b0, 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("err_sticky", 32'(error), 32'd1);

        fill_random(2);
        wbase = wr_log.size();
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 1, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 2, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("abort_nowr", 32'(wr_log.size() - wbase), 32'd0);
        run_load(16'd2, 8'h00, 1'b0, 2);

        fill_random(1);
        run_load(16'd1, 8'h00, 1'b1, 3);

        fill_random(MEM_WORDS);
        run_load(16'(MEM_WORDS), 8'h00, 1'b0, 1);
        run_load(16'(MEM_WORDS + 1), 8'h00, 1'b0, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        words_q.delete();
        words_q.push_back(32'h1122_3344);
        run_load(16'd1, 8'h00, 1'b0, 1);
        run_load(16'd1, 8'h45, 1'b0, 1);
`endif

        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(0, 8);
            fill_random(n);
            cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_load(16'(n), cx, 1'b1, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
